// File: rtl/demultiplexor_serial_32.sv
// Serial-to-parallel 1:32 demultiplexer with its own 5-bit select counter; optional parity bit via DEMUX_PARITY_EN.
// Latency: y/y_valid registered, visible right after the edge that accepts the last bit of a frame.
// Backpressure: none; d_valid qualifies each bit, gaps of any length are held without state change.
module demultiplexor_serial_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync,
    input  logic        d,
    input  logic        d_valid,
    output logic [4:0]  s,
    output logic [31:0] y,
    output logic        y_valid,
    output logic        busy
`ifdef DEMUX_PARITY_EN
    ,
    output logic        parity_err
`endif
);

`ifdef DEMUX_PARITY_EN
    typedef enum logic {ST_COLLECT = 1'b0, ST_PAR = 1'b1} state_t;
`else
    typedef enum logic {ST_COLLECT = 1'b0} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_s;
    logic [4:0]  w_s_nxt;
    logic [31:0] r_shadow;
    logic [31:0] w_shadow_nxt;
    logic [31:0] r_y;
    logic [31:0] w_y_nxt;
    logic        r_y_valid;
    logic        w_y_valid_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
`ifdef DEMUX_PARITY_EN
    logic        r_parity_err;
    logic        w_parity_err_nxt;
`endif

    // State register: reset discards any partial frame asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_COLLECT;
            r_s       <= 5'd0;
            r_shadow  <= 32'h0000_0000;
            r_y       <= 32'h0000_0000;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_shadow  <= w_shadow_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_busy    <= w_busy_nxt;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // Next-state logic: sync wins over everything, then accepted bits advance the frame.
    always_comb begin
        w_state_nxt   = r_state;
        w_s_nxt       = r_s;
        w_shadow_nxt  = r_shadow;
        w_y_nxt       = r_y;
        w_y_valid_nxt = 1'b0;
`ifdef DEMUX_PARITY_EN
        w_parity_err_nxt = r_parity_err;
`endif
        if (sync) begin
            // Restart the frame; a coincident bit becomes index 0 of the new frame.
            w_state_nxt = ST_COLLECT;
            if (d_valid) begin
                w_shadow_nxt[0] = d;
                w_s_nxt         = 5'd1;
            end else begin
                w_s_nxt = 5'd0;
            end
        end else if (d_valid) begin
            case (r_state)
                ST_COLLECT: begin
                    w_shadow_nxt[r_s] = d;
                    if (r_s == 5'd31) begin
`ifdef DEMUX_PARITY_EN
                        // Hold s at 31 and wait for the parity bit.
                        w_state_nxt = ST_PAR;
`else
                        w_y_nxt       = {d, r_shadow[30:0]};
                        w_y_valid_nxt = 1'b1;
                        w_s_nxt       = 5'd0;
`endif
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
`ifdef DEMUX_PARITY_EN
                ST_PAR: begin
                    // Word is published even when parity is bad; the flag rides with y_valid.
                    w_y_nxt          = r_shadow;
                    w_y_valid_nxt    = 1'b1;
                    w_parity_err_nxt = (^r_shadow) ^ d;
                    w_s_nxt          = 5'd0;
                    w_state_nxt      = ST_COLLECT;
                end
`endif
                default: begin
                    w_state_nxt = ST_COLLECT;
                    w_s_nxt     = 5'd0;
                end
            endcase
        end
    end

    // busy is registered from the next-state values so it tracks s without a lag.
    always_comb begin
`ifdef DEMUX_PARITY_EN
        w_busy_nxt = (w_s_nxt != 5'd0) || (w_state_nxt == ST_PAR);
`else
        w_busy_nxt = (w_s_nxt != 5'd0);
`endif
    end

    assign s       = r_s;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign busy    = r_busy;
`ifdef DEMUX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_demultiplexor_serial_32.sv
// Directed bench for demultiplexor_serial_32: framing, gaps, sync, async reset, optional parity.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// DUT has no backpressure; every wait is a fixed number of cycles.
module tb_demultiplexor_serial_32;

`ifdef DEMUX_PARITY_EN
    localparam int FRAME_LEN = 33;
`else
    localparam int FRAME_LEN = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        sync;
    logic        d;
    logic        d_valid;
    logic [4:0]  s;
    logic [31:0] y;
    logic        y_valid;
    logic        busy;
`ifdef DEMUX_PARITY_EN
    logic        parity_err;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int pulses  = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;
    logic [31:0] exp_y = 32'h0;

    demultiplexor_serial_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync    (sync),
        .d       (d),
        .d_valid (d_valid),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
`ifdef DEMUX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; tracks y_valid pulses and when they happen.
    task automatic drive(input logic v, input logic b, input logic sy);
        d_valid = v;
        d       = b;
        sync    = sy;
        @(posedge clk);
        #1;
        cyc++;
        if (y_valid === 1'b1) begin
            pulses++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
        d_valid = 1'b0;
        sync    = 1'b0;
    endtask

    // Sends a full frame (plus parity bit when enabled); optional 3-cycle gaps after every 5th bit.
    task automatic send_word(input logic [31:0] w, input bit gaps, input logic pflip);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, w[i], 1'b0);
            if (gaps && (i % 5 == 4)) begin
                for (int g = 0; g < 3; g++) drive(1'b0, 1'b1, 1'b0);
                chk($sformatf("gap_s_%0d", i), {27'd0, s}, (i + 1) & 31);
                chk($sformatf("gap_y_%0d", i), y, exp_y);
            end
        end
`ifdef DEMUX_PARITY_EN
        drive(1'b1, (^w) ^ pflip, 1'b0);
`else
        if (pflip) chk("pflip_unused", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] wb;
        rst_n   = 1'b0;
        sync    = 1'b0;
        d       = 1'b0;
        d_valid = 1'b0;
        #12;
        chk("rst_s", {27'd0, s}, 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_yv", {31'd0, y_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Back-to-back frames with d_valid held high.
        pulses = 0;
        drive(1'b1, 1'b1, 1'b0);
        chk("t1_s_after_bit0", {27'd0, s}, 32'd1);
        chk("t1_busy_after_bit0", {31'd0, busy}, 32'd1);
        wb = 32'hA5C3_0F81;
        for (int i = 1; i < 32; i++) drive(1'b1, wb[i], 1'b0);
`ifdef DEMUX_PARITY_EN
        chk("t1_s_in_par", {27'd0, s}, 32'd31);
        chk("t1_busy_in_par", {31'd0, busy}, 32'd1);
        drive(1'b1, ^wb, 1'b0);
`endif
        chk("t1_yv", {31'd0, y_valid}, 32'd1);
        chk("t1_y", y, 32'hA5C3_0F81);
        chk("t1_s", {27'd0, s}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        exp_y = 32'hA5C3_0F81;
        send_word(32'h5A5A_00FF, 1'b0, 1'b0);
        chk("t1b_y", y, 32'h5A5A_00FF);
        chk("t1b_spacing", last_pulse_cyc - prev_pulse_cyc, FRAME_LEN);
        drive(1'b0, 1'b0, 1'b0);
        chk("t1_yv_one_cycle", {31'd0, y_valid}, 32'd0);
        chk("t1_pulses", pulses, 2);
        exp_y = 32'h5A5A_00FF;

        // Gapped frame.
        pulses = 0;
        send_word(32'hA5C3_0F81, 1'b1, 1'b0);
        chk("t2_y", y, 32'hA5C3_0F81);
        chk("t2_yv", {31'd0, y_valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("t2_pulses", pulses, 1);
        exp_y = 32'hA5C3_0F81;

        // Partial frame discarded by sync alone.
        pulses = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk("t3_s_after_sync", {27'd0, s}, 32'd0);
        chk("t3_busy_after_sync", {31'd0, busy}, 32'd0);
        chk("t3_y_held", y, exp_y);
        chk("t3_yv_after_sync", {31'd0, y_valid}, 32'd0);
        send_word(32'h0000_FFFF, 1'b0, 1'b0);
        chk("t3_y", y, 32'h0000_FFFF);
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_pulses", pulses, 1);
        exp_y = 32'h0000_FFFF;

        // sync+d_valid at index 31 beats frame completion.
        pulses = 0;
        for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 1'b0);
        chk("t4_s_at_31", {27'd0, s}, 32'd31);
        drive(1'b1, 1'b1, 1'b1);
        chk("t4_yv", {31'd0, y_valid}, 32'd0);
        chk("t4_s", {27'd0, s}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_y_held", y, 32'h0000_FFFF);
        wb = 32'h1234_5679;
        for (int i = 1; i < 32; i++) drive(1'b1, wb[i], 1'b0);
`ifdef DEMUX_PARITY_EN
        drive(1'b1, ^wb, 1'b0);
`endif
        chk("t4_y", y, 32'h1234_5679);
        chk("t4_pulses", pulses, 1);
        exp_y = 32'h1234_5679;

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
        chk("t5_s_before", {27'd0, s}, 32'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_s", {27'd0, s}, 32'd0);
        chk("t5_y", y, 32'h0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_y = 32'h0;
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t5_y_after", y, 32'hDEAD_BEEF);

`ifdef DEMUX_PARITY_EN
        // Parity: good then bad, 33 cycles apart.
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) drive(1'b1, (i == 0), 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("t6_yv1", {31'd0, y_valid}, 32'd1);
        chk("t6_perr1", {31'd0, parity_err}, 32'd0);
        chk("t6_y1", y, 32'h0000_0001);
        for (int i = 0; i < 32; i++) drive(1'b1, (i < 2), 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("t6_yv2", {31'd0, y_valid}, 32'd1);
        chk("t6_perr2", {31'd0, parity_err}, 32'd1);
        chk("t6_y2", y, 32'h0000_0003);
        chk("t6_spacing", last_pulse_cyc - prev_pulse_cyc, 33);
        drive(1'b0, 1'b0, 1'b0);
        chk("t6_perr_hold", {31'd0, parity_err}, 32'd1);
        // sync while waiting for the parity bit.
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk("t6_sync_par_s", {27'd0, s}, 32'd0);
        chk("t6_sync_par_busy", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demultiplexor_serial_32.md
# demultiplexor_serial_32

Sequential 1-to-32 demultiplexer. It deassembles a serial bit stream into a 32-bit parallel word, one bit per accepted cycle, with its own 5-bit select counter. It sits on the receive side of the 32:1 multiplexer path: the multiplexer, stepped by a select counter, serializes 32 inputs, and this block routes each arriving bit back to the output position of the same index. It presents each completed word with a one-cycle valid pulse.

## Interface
Parameters:
- none

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronized externally
- sync  input  1  frame restart; discards any partial frame and forces the index to 0
- d  input  1  serial data bit
- d_valid  input  1  qualifies d; one bit is accepted per cycle in which it is high
- s  output  5  index of the next bit to be accepted (the select value of the matching mux)
- y  output  32  last completed word; y[i] is the bit accepted while s==i
- y_valid  output  1  one-cycle pulse when y has just been updated
- busy  output  1  high while a partial frame is held (at least one bit accepted, word not yet complete)
- parity_err  output  1  present only with DEMUX_PARITY_EN; see Configuration

## Operation
- Internal state:
  - 32-bit shadow register
  - 5-bit index counter, which drives s
  - FSM with states COLLECT and, under the macro, PAR
- Accepted bit (d_valid=1 in COLLECT):
  - shadow[s] <= d
  - s increments modulo 32
- Bit at s==31:
  - without the macro, completes the frame: y <= shadow with bit 31 replaced by d, y_valid <= 1, s wraps to 0
  - with the macro, moves the FSM to PAR; s stays at 31
- y changes only at frame completion. It holds the previous word stably for the whole of the next frame.
- d_valid=0: no state change. Gaps of any length between bits are legal.
- sync=1 without d_valid:
  - s <= 0, FSM <= COLLECT, busy <= 0
  - the shadow contents are don't-care; y and y_valid are unaffected
- sync=1 with d_valid=1 in the same cycle:
  - the bit is accepted as index 0 of a new frame; s <= 1
  - sync has priority over a frame completion in the same cycle: no y update, no pulse
- busy = (s != 0) or (FSM == PAR)
- Reset values: s=0, y=32'h0000_0000, y_valid=0, busy=0, parity_err=0, FSM=COLLECT, shadow=0.
- Reset asserted mid-frame discards the partial frame immediately and asynchronously.

## Timing
- All outputs are registered.
- Latency:
  - y/y_valid go high in the cycle after the edge that accepts the last bit (bit 31, or the parity bit under the macro)
  - y_valid is high for exactly one cycle
- Throughput: back-to-back frames with d_valid held high continuously; no dead cycle between frames.
  - Without the macro, y_valid pulses every 32 cycles.
  - With the macro, y_valid pulses every 33 cycles.
- s updates on the same edge that accepts a bit. A serializer driving its mux from s sees the next index one cycle after acceptance.

## Configuration
- Macro: DEMUX_PARITY_EN
- Defined:
  - each frame carries a 33rd bit, even parity over the 32 data bits
  - in PAR, the next accepted bit p completes the frame: y <= shadow, y_valid <= 1, parity_err <= ^shadow ^ p, s <= 0, FSM <= COLLECT
  - y is updated even when parity is bad
  - parity_err is valid with y_valid and holds its value until the next y_valid
  - sync in PAR returns to COLLECT with s=0
- Undefined:
  - no PAR state and no parity_err port
  - frames are exactly 32 bits

## Test plan
- Reset, then 32 back-to-back bits with d_valid=1 carrying 32'hA5C3_0F81, LSB first (index 0 first) -> y_valid pulses once the cycle after bit 31; y=32'hA5C3_0F81; s=0; busy=0.
- Same word with d_valid deasserted for 3 cycles after every 5th bit -> identical y, one pulse; s and y stable during gaps.
- Send 10 bits, pulse sync alone, then a full frame of 32'h0000_FFFF -> y=32'h0000_FFFF, exactly one pulse; the first 10 bits leave no trace.
- Send 31 bits of frame A, then assert sync+d_valid with d=1 -> no pulse; s=1; busy=1; the next 31 bits complete frame B with B[0]=1.
- Assert rst_n low after 20 bits of a frame -> s=0, y=0, busy=0 immediately, without waiting for a clock edge; the next full frame decodes correctly.
- With DEMUX_PARITY_EN, send 32'h0000_0001 with p=1, then 32'h0000_0003 with p=1 -> first frame: y_valid with parity_err=0; second frame: parity_err=1 and y=32'h0000_0003; pulse 33 cycles apart.
